// File: rtl/vga_scanout_pkg.sv
// Shared VGA 640x480 timing constants, framebuffer geometry and fetch FSM states.
package vga_scanout_pkg;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;  // first h after sync
  localparam logic [9:0] H_TOTAL      = 10'd800;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;  // first v after sync
  localparam logic [9:0] V_TOTAL      = 10'd525;

  localparam logic [3:0] SCALE_LAST   = 4'd9;     // scale factor 10
  localparam int         FB_W         = 64;
  localparam int         FB_H         = 32;
  localparam int         FB_ROW_BYTES = FB_W / 8;
  localparam int         BAND_LINES   = FB_H * 10;

  typedef enum logic [1:0] {
    F_IDLE,
    F_READ,
    F_CAPTURE
  } fetch_state_e;

endpackage

// File: rtl/vga_scanout_timing.sv
// Horizontal/vertical counters plus registered sync, active and vblank decode.
module vga_timing
  import vga_scanout_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       active_o,
  output logic       vblank_o
);

  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hsync_q, vsync_q, active_q, vblank_q;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_TOTAL - 10'd1) begin
      h_d = 10'd0;
      v_d = (v_q == V_TOTAL - 10'd1) ? 10'd0 : v_q + 10'd1;
    end
  end

  // Decode uses the pre-advance position so every output lags by one tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      vblank_q <= 1'b0;
    end else if (tick_i) begin
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= !(h_q >= H_SYNC_START && h_q < H_SYNC_END);
      vsync_q  <= !(v_q >= V_SYNC_START && v_q < V_SYNC_END);
      active_q <= (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
      vblank_q <= (v_q >= V_VISIBLE);
    end
  end

  assign h_o      = h_q;
  assign v_o      = v_q;
  assign hsync_o  = hsync_q;
  assign vsync_o  = vsync_q;
  assign active_o = active_q;
  assign vblank_o = vblank_q;

endmodule

// File: rtl/vga_scanout.sv
// 64x32 1bpp framebuffer scanout, 10x scaled into a 640x320 band of a 640x480 VGA frame.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter logic [11:0] FB_BASE  = 12'hF00,
  parameter int          Y_OFFSET = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        timer_vga_tick,
  output logic        vga_mem_read,
  output logic [11:0] vga_mem_addr,
  input  logic [7:0]  vga_mem_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_pixel,
  output logic        vga_active,
  output logic        vga_vblank
);

  localparam logic [9:0] Y_START = 10'(Y_OFFSET);
  localparam logic [9:0] Y_END   = 10'(Y_OFFSET + BAND_LINES);

  logic [9:0] h, v;

  vga_timing u_timing (
    .clk_i    (clk),
    .rst_i    (reset),
    .tick_i   (timer_vga_tick),
    .h_o      (h),
    .v_o      (v),
    .hsync_o  (vga_hsync),
    .vsync_o  (vga_vsync),
    .active_o (vga_active),
    .vblank_o (vga_vblank)
  );

  logic [3:0]      hsub_q, hsub_d, vsub_q, vsub_d;
  logic [5:0]      fb_x_q, fb_x_d;
  logic [4:0]      fb_y_q, fb_y_d;
  logic            pixel_q, pixel_d;
  logic [7:0][7:0] row_buf_q;

  fetch_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [4:0]   fetch_row_q, fetch_row_d;
  logic         capture;

  logic [9:0] v_next;
  logic       line_end, next_in_band, in_band, fetch_start;
  logic [4:0] next_row;

  always_comb begin
    line_end     = (h == H_TOTAL - 10'd1);
    v_next       = (v == V_TOTAL - 10'd1) ? 10'd0 : v + 10'd1;
    next_in_band = (v_next >= Y_START) && (v_next < Y_END);
    next_row     = (v_next == Y_START) ? 5'd0 :
                   (vsub_q == SCALE_LAST) ? fb_y_q + 5'd1 : fb_y_q;
    in_band      = (h < H_VISIBLE) && (v >= Y_START) && (v < Y_END);
    fetch_start  = timer_vga_tick && (h == H_VISIBLE - 10'd1) && next_in_band;
  end

  // Mod-10 sub-counters track h/10 and (v-Y_OFFSET)/10; values outside the band are don't-care.
  always_comb begin
    hsub_d  = hsub_q;
    fb_x_d  = fb_x_q;
    vsub_d  = vsub_q;
    fb_y_d  = fb_y_q;
    pixel_d = in_band & row_buf_q[fb_x_q[5:3]][3'd7 - fb_x_q[2:0]];
    if (line_end) begin
      hsub_d = '0;
      fb_x_d = '0;
      if (v_next == Y_START) begin
        vsub_d = '0;
        fb_y_d = '0;
      end else if (vsub_q == SCALE_LAST) begin
        vsub_d = '0;
        fb_y_d = fb_y_q + 5'd1;
      end else begin
        vsub_d = vsub_q + 4'd1;
      end
    end else if (hsub_q == SCALE_LAST) begin
      hsub_d = '0;
      fb_x_d = fb_x_q + 6'd1;
    end else begin
      hsub_d = hsub_q + 4'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fetch_row_d  = fetch_row_q;
    vga_mem_read = 1'b0;
    vga_mem_addr = '0;
    capture      = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (fetch_start) begin
          state_d     = F_READ;
          idx_d       = '0;
          fetch_row_d = next_row;
        end
      end
      F_READ: begin
        vga_mem_read = 1'b1;
        vga_mem_addr = FB_BASE + {4'd0, fetch_row_q, 3'b000} + {9'd0, idx_q};
        state_d      = F_CAPTURE;
      end
      F_CAPTURE: begin
        capture = 1'b1;
        if (idx_q == 3'd7) begin
          state_d = F_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = F_READ;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsub_q      <= '0;
      fb_x_q      <= '0;
      vsub_q      <= '0;
      fb_y_q      <= '0;
      pixel_q     <= 1'b0;
      row_buf_q   <= '0;
      state_q     <= F_IDLE;
      idx_q       <= '0;
      fetch_row_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fetch_row_q <= fetch_row_d;
      if (capture) row_buf_q[idx_q] <= vga_mem_data;
      if (timer_vga_tick) begin
        hsub_q  <= hsub_d;
        fb_x_q  <= fb_x_d;
        vsub_q  <= vsub_d;
        fb_y_q  <= fb_y_d;
        pixel_q <= pixel_d;
      end
    end
  end

  assign vga_pixel = pixel_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench: band moved to line 2 and base to 0xFF8 so a few lines cover fetch, scaling and address wrap.
module tb_vga_scanout;

  localparam logic [11:0] FB_BASE = 12'hFF8;
  localparam int          YO      = 2;

  logic        clk = 1'b0;
  logic        reset, tick;
  logic        mem_read;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        hsync, vsync, pixel, active, vblank;

  always #5 clk = ~clk;

  vga_scanout #(.FB_BASE(FB_BASE), .Y_OFFSET(YO)) dut (
    .clk            (clk),
    .reset          (reset),
    .timer_vga_tick (tick),
    .vga_mem_read   (mem_read),
    .vga_mem_addr   (mem_addr),
    .vga_mem_data   (mem_data),
    .vga_hsync      (hsync),
    .vga_vsync      (vsync),
    .vga_pixel      (pixel),
    .vga_active     (active),
    .vga_vblank     (vblank)
  );

  logic [7:0] mem [4096];
  always @(posedge clk) if (mem_read) mem_data <= mem[mem_addr];

  typedef struct {
    int   v;
    int   h;
    logic hs;
    logic act;
    logic pix;
  } spot_t;

  spot_t       spots[$];
  logic [4:0]  exp_q[$];
  logic [11:0] rd_q[$];
  int vectors = 0, miscompares = 0;
  int t_cnt = 0, n_reads = 0, exp_reads = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Reference: {hsync, vsync, active, vblank, pixel} for tick index t.
  function automatic logic [4:0] model(input int t);
    int h, v, row, x;
    logic hs, vs, act, vb, pix;
    logic [11:0] a;
    h   = t % 800;
    v   = (t / 800) % 525;
    hs  = !(h >= 656 && h < 752);
    vs  = !(v >= 490 && v < 492);
    act = (h < 640) && (v < 480);
    vb  = (v >= 480);
    pix = 1'b0;
    if (act && v >= YO && v < YO + 320) begin
      row = (v - YO) / 10;
      x   = h / 10;
      a   = FB_BASE + 12'(row * 8 + x / 8);
      pix = mem[a][7 - (x % 8)];
    end
    return {hs, vs, act, vb, pix};
  endfunction

  task automatic do_tick();
    int h, v, vn;
    h = t_cnt % 800;
    v = (t_cnt / 800) % 525;
    tick = 1'b1;
    exp_q.push_back(model(t_cnt));
    if (h == 639) begin
      vn = (v + 1) % 525;
      if (vn >= YO && vn < YO + 320) begin
        for (int i = 0; i < 8; i++) rd_q.push_back(FB_BASE + 12'(((vn - YO) / 10) * 8 + i));
        exp_reads += 8;
      end
    end
    @(negedge clk);
    tick = 1'b0;
    check($sformatf("out_t%0d", t_cnt), {27'd0, hsync, vsync, active, vblank, pixel}, {27'd0, exp_q.pop_front()});
    t_cnt++;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mem_read) begin
      n_reads++;
      if (rd_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL read_unexpected: addr %0h strobed, expected no read", mem_addr);
      end else begin
        check("read_addr", {20'd0, mem_addr}, {20'd0, rd_q.pop_front()});
      end
    end
  end

  task automatic add_spot(input int v, input int h, input logic hs, input logic act, input logic pix);
    spot_t s;
    s.v = v; s.h = h; s.hs = hs; s.act = act; s.pix = pix;
    spots.push_back(s);
  endtask

  initial begin
    reset = 1'b1;
    tick  = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'hFF8] = 8'h80;  // row 0 byte 0
    mem[12'hFFF] = 8'h01;  // row 0 byte 7
    mem[12'h000] = 8'hFF;  // row 1 bytes, past the 12-bit wrap
    mem[12'h001] = 8'h0F;
    mem[12'h007] = 8'hA5;
    mem[12'hFF7] = 8'hFF;  // decoys around the real rows
    mem[12'h008] = 8'hFF;
    mem[12'hF00] = 8'hFF;

    add_spot(0,  0,   1, 1, 0);
    add_spot(1,  0,   1, 1, 0);
    add_spot(2,  0,   1, 1, 1);
    add_spot(2,  9,   1, 1, 1);
    add_spot(2,  10,  1, 1, 0);
    add_spot(2,  629, 1, 1, 0);
    add_spot(2,  630, 1, 1, 1);
    add_spot(2,  639, 1, 1, 1);
    add_spot(2,  640, 1, 0, 0);
    add_spot(2,  655, 1, 0, 0);
    add_spot(2,  656, 0, 0, 0);
    add_spot(2,  751, 0, 0, 0);
    add_spot(2,  752, 1, 0, 0);
    add_spot(2,  799, 1, 0, 0);
    add_spot(11, 5,   1, 1, 1);
    add_spot(12, 5,   1, 1, 1);
    add_spot(12, 79,  1, 1, 1);
    add_spot(12, 80,  1, 1, 0);
    add_spot(12, 120, 1, 1, 1);
    add_spot(12, 560, 1, 1, 1);
    add_spot(12, 570, 1, 1, 0);
    add_spot(12, 580, 1, 1, 1);

    repeat (3) @(negedge clk);
    check("reset_outs", {27'd0, hsync, vsync, active, vblank, pixel}, 32'b11000);
    check("reset_read", {31'd0, mem_read}, 32'd0);
    check("reset_addr", {20'd0, mem_addr}, 32'd0);
    reset = 1'b0;

    foreach (spots[k]) begin
      while (t_cnt <= spots[k].v * 800 + spots[k].h) do_tick();
      check($sformatf("spot_v%0d_h%0d", spots[k].v, spots[k].h),
            {29'd0, hsync, active, pixel}, {29'd0, spots[k].hs, spots[k].act, spots[k].pix});
    end

    // Line 13 h=639 starts the fetch for line 14; reset lands mid-fetch alongside a tick.
    while (t_cnt <= 13 * 800 + 639) do_tick();
    @(negedge clk);
    check("fetch_in_progress", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    check("abort_read", {31'd0, mem_read}, 32'd0);
    check("abort_addr", {20'd0, mem_addr}, 32'd0);
    check("abort_outs", {27'd0, hsync, vsync, active, vblank, pixel}, 32'b11000);
    reset = 1'b0;
    tick  = 1'b0;
    rd_q.delete();
    t_cnt     = 0;
    n_reads   = 0;
    exp_reads = 0;
    @(negedge clk);
    check("no_read_after_abort", {31'd0, mem_read}, 32'd0);

    // Counters restart at 0: line 2 must be refetched and scanned again.
    while (t_cnt <= 2 * 800 + 700) do_tick();
    repeat (20) @(negedge clk);
    check("read_count", n_reads, exp_reads);
    check("reads_pending", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
